// File: rtl/osc_bank_synth_if.sv
// Port bundle for osc_bank_synth: per-voice config write strobe plus the sample valid/ready output.
// The design sits on the slave side. The bench or parent drives the master side.
interface osc_bank_synth_if #(
  parameter int N_OSC    = 64,
  parameter int PHASE_W  = 24,
  parameter int SAMPLE_W = 16
);
  localparam int SEL_W = $clog2(N_OSC);

  logic                       i_cfg_valid;
  logic [SEL_W-1:0]           i_cfg_sel;
  logic [PHASE_W-1:0]         i_cfg_step;
  logic [1:0]                 i_cfg_wave;
  logic                       i_cfg_en;
  logic                       i_cfg_prst;
  logic signed [SAMPLE_W-1:0] o_sample;
  logic                       o_valid;
  logic                       i_ready;
  logic                       o_overrun;
  logic [1:0]                 o_dbg_state;

  modport master (
    output i_cfg_valid, i_cfg_sel, i_cfg_step, i_cfg_wave, i_cfg_en, i_cfg_prst, i_ready,
    input  o_sample, o_valid, o_overrun, o_dbg_state
  );

  modport slave (
    input  i_cfg_valid, i_cfg_sel, i_cfg_step, i_cfg_wave, i_cfg_en, i_cfg_prst, i_ready,
    output o_sample, o_valid, o_overrun, o_dbg_state
  );
endinterface

// File: rtl/osc_bank_synth.sv
// Time-multiplexed oscillator bank: one shared phase/waveform datapath scans N_OSC voices per
// audio tick and emits a normalised signed mono mix over a valid/ready output.
module osc_bank_synth #(
  parameter int N_OSC    = 64,
  parameter int PHASE_W  = 24,
  parameter int SAMPLE_W = 16,
  parameter int TICK_DIV = 1000
) (
  input  logic              i_clk48,
  input  logic              i_rst48_n,
  osc_bank_synth_if.slave   bus
);
  localparam int SEL_W = $clog2(N_OSC);
  localparam int ACC_W = SAMPLE_W + SEL_W;
  localparam int ACT_W = SEL_W + 1;
  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [SAMPLE_W-1:0] MSB_MASK = {1'b1, {(SAMPLE_W-1){1'b0}}};

  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_NORM, ST_OUT} state_e;

  state_e                     state_q, state_d;
  logic [SEL_W-1:0]           k_q, k_d;
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic [ACT_W-1:0]           act_q, act_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [SAMPLE_W-1:0]        sample_q, sample_d;
  logic                       valid_q, valid_d;
  logic                       overrun_q, overrun_d;
  logic [PHASE_W-1:0]         phase_q [N_OSC];
  logic [PHASE_W-1:0]         phase_d [N_OSC];
  logic [PHASE_W-1:0]         step_q  [N_OSC];
  logic [PHASE_W-1:0]         step_d  [N_OSC];
  logic [1:0]                 wave_q  [N_OSC];
  logic [1:0]                 wave_d  [N_OSC];
  logic                       en_q    [N_OSC];
  logic                       en_d    [N_OSC];

  logic                       tick;
  logic [SAMPLE_W:0]          p;
  logic [SAMPLE_W-1:0]        wave_s;
  logic                       voice_on;
  int                         norm_sh;
  logic signed [ACC_W-1:0]    acc_shr;

  assign tick            = (cnt_q == '0);
  assign bus.o_sample    = sample_q;
  assign bus.o_valid     = valid_q;
  assign bus.o_overrun   = overrun_q;
  assign bus.o_dbg_state = state_q;

  // Waveform of the voice currently under the scan index, from its pre-increment phase.
  always_comb begin
    p        = phase_q[k_q][PHASE_W-1 -: SAMPLE_W+1];
    voice_on = en_q[k_q] && (wave_q[k_q] != 2'd3);
    case (wave_q[k_q])
      2'd0:    wave_s = p[SAMPLE_W:1] ^ MSB_MASK;
      2'd1:    wave_s = p[SAMPLE_W] ? MSB_MASK : ~MSB_MASK;
      2'd2:    wave_s = (p[SAMPLE_W] ? ~p[SAMPLE_W-1:0] : p[SAMPLE_W-1:0]) ^ MSB_MASK;
      default: wave_s = '0;
    endcase
  end

  // Normalise by the smallest power of two not below the active voice count.
  always_comb begin
    norm_sh = 0;
    for (int s = 0; s < ACT_W; s++) begin
      if ((1 << s) < int'(act_q)) norm_sh = s + 1;
    end
    acc_shr = acc_q >>> norm_sh;
  end

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    acc_d     = acc_q;
    act_d     = act_q;
    sample_d  = sample_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    phase_d   = phase_q;
    step_d    = step_q;
    wave_d    = wave_q;
    en_d      = en_q;
    cnt_d     = (cnt_q == CNT_W'(TICK_DIV - 1)) ? '0 : cnt_q + 1'b1;

    // Output handshake: o_valid holds o_sample stable until a cycle with o_valid && i_ready.
    case (state_q)
      ST_IDLE: begin
        if (tick) begin
          state_d = ST_SCAN;
          k_d     = '0;
          acc_d   = '0;
          act_d   = '0;
        end
      end
      ST_SCAN: begin
        if (voice_on) begin
          acc_d = acc_q + {{SEL_W{wave_s[SAMPLE_W-1]}}, wave_s};
          act_d = act_q + 1'b1;
        end
        phase_d[k_q] = phase_q[k_q] + step_q[k_q];
        if (k_q == SEL_W'(N_OSC - 1)) state_d = ST_NORM;
        else                          k_d     = k_q + 1'b1;
      end
      ST_NORM: begin
        sample_d = (act_q == '0) ? '0 : acc_shr[SAMPLE_W-1:0];
        valid_d  = 1'b1;
        state_d  = ST_OUT;
      end
      ST_OUT: begin
        if (valid_q && bus.i_ready) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end
        // A tick seen here is lost even if the sample is accepted this same cycle.
        if (tick) overrun_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    // Config lands after the scan update so a phase reset wins over the same-cycle advance.
    if (bus.i_cfg_valid) begin
      step_d[bus.i_cfg_sel] = bus.i_cfg_step;
      wave_d[bus.i_cfg_sel] = bus.i_cfg_wave;
      en_d[bus.i_cfg_sel]   = bus.i_cfg_en;
      if (bus.i_cfg_prst) phase_d[bus.i_cfg_sel] = '0;
    end
  end

  always_ff @(posedge i_clk48 or negedge i_rst48_n) begin
    if (!i_rst48_n) begin
      state_q   <= ST_IDLE;
      k_q       <= '0;
      acc_q     <= '0;
      act_q     <= '0;
      cnt_q     <= '0;
      sample_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      for (int i = 0; i < N_OSC; i++) begin
        phase_q[i] <= '0;
        step_q[i]  <= '0;
        wave_q[i]  <= '0;
        en_q[i]    <= 1'b0;
      end
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      acc_q     <= acc_d;
      act_q     <= act_d;
      cnt_q     <= cnt_d;
      sample_q  <= sample_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      phase_q   <= phase_d;
      step_q    <= step_d;
      wave_q    <= wave_d;
      en_q      <= en_d;
    end
  end
endmodule

// File: tb/tb_osc_bank_synth.sv
// Directed bench for osc_bank_synth with 4 voices and a 16-cycle audio tick.
// Cycle numbers count posedges since reset release, so ticks fall on multiples of 16.
module tb_osc_bank_synth;
  localparam int N  = 4;
  localparam int PW = 24;
  localparam int SW = 16;
  localparam int TD = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  logic [SW-1:0] exp_q[$];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  osc_bank_synth_if #(.N_OSC(N), .PHASE_W(PW), .SAMPLE_W(SW)) bus ();

  osc_bank_synth #(.N_OSC(N), .PHASE_W(PW), .SAMPLE_W(SW), .TICK_DIV(TD)) dut (
    .i_clk48   (clk),
    .i_rst48_n (rst_n),
    .bus       (bus)
  );

  task automatic release_reset();
    repeat (2) @(negedge clk);
    bus.i_cfg_valid = 1'b0;
    bus.i_cfg_prst  = 1'b0;
    bus.i_ready     = 1'b1;
    rst_n           = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    release_reset();
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic cfg(input int sel, input logic [PW-1:0] step, input logic [1:0] wave,
                     input logic en, input logic prst);
    bus.i_cfg_valid = 1'b1;
    bus.i_cfg_sel   = 2'(sel);
    bus.i_cfg_step  = step;
    bus.i_cfg_wave  = wave;
    bus.i_cfg_en    = en;
    bus.i_cfg_prst  = prst;
    @(negedge clk);
    bus.i_cfg_valid = 1'b0;
    bus.i_cfg_prst  = 1'b0;
  endtask

  task automatic next_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.o_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bus.i_cfg_valid = 1'b0; bus.i_cfg_sel = '0; bus.i_cfg_step = '0;
    bus.i_cfg_wave  = '0;   bus.i_cfg_en  = 1'b0; bus.i_cfg_prst = 1'b0;
    bus.i_ready     = 1'b1;
    #12;
    total++; if (bus.o_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", bus.o_valid); end
    total++; if (bus.o_sample !== 16'h0000) begin bad++; $display("FAIL reset_sample: got %h want 0000", bus.o_sample); end
    total++; if (bus.o_overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun: got %b want 0", bus.o_overrun); end
    total++; if (bus.o_dbg_state !== 2'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", bus.o_dbg_state); end
    release_reset();
  endtask

  task automatic test_silent();
    bit ok;
    do_reset();
    next_valid(ok);
    total++; if (!ok) begin bad++; $display("FAIL silent_first_timeout: got no o_valid want o_valid within 40 cycles"); end
    total++; if (bus.o_sample !== 16'h0000) begin bad++; $display("FAIL silent_first_sample: got %h want 0000", bus.o_sample); end
    total++; if (cyc !== 6) begin bad++; $display("FAIL silent_first_latency: got cycle %0d want 6", cyc); end
    wait_cyc(7);
    cfg(0, 24'h100000, 2'd3, 1'b1, 1'b0);
    cfg(1, 24'h100000, 2'd0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      next_valid(ok);
      total++; if (!ok) begin bad++; $display("FAIL silent_timeout: got no o_valid want o_valid (tick %0d)", i); end
      total++; if (bus.o_sample !== 16'h0000) begin bad++; $display("FAIL silent_sample: got %h want 0000 (tick %0d)", bus.o_sample, i); end
      total++; if (cyc !== 22 + TD * i) begin bad++; $display("FAIL silent_latency: got cycle %0d want %0d", cyc, 22 + TD * i); end
    end
  endtask

  task automatic test_square();
    bit ok;
    do_reset();
    wait_cyc(7);
    cfg(0, 24'h0, 2'd1, 1'b1, 1'b0);
    cfg(1, 24'h0, 2'd1, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      next_valid(ok);
      total++; if (!ok) begin bad++; $display("FAIL square_timeout: got no o_valid want o_valid (tick %0d)", i); end
      total++; if (bus.o_sample !== 16'h7FFF) begin bad++; $display("FAIL square_sample: got %h want 7fff", bus.o_sample); end
      total++; if (cyc !== 22 + TD * i) begin bad++; $display("FAIL square_latency: got cycle %0d want %0d", cyc, 22 + TD * i); end
    end
    wait_cyc(39);
    cfg(2, 24'h0, 2'd1, 1'b1, 1'b0);
    next_valid(ok);
    total++; if (bus.o_sample !== 16'h5FFF) begin bad++; $display("FAIL square_three_voice: got %h want 5fff", bus.o_sample); end
  endtask

  task automatic test_triangle();
    bit ok;
    logic [SW-1:0] tri_exp [4];
    tri_exp = '{16'h8000, 16'h0000, 16'h7FFF, 16'hFFFF};
    do_reset();
    wait_cyc(7);
    cfg(0, 24'h400000, 2'd2, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      next_valid(ok);
      total++; if (bus.o_sample !== tri_exp[i]) begin bad++; $display("FAIL triangle_sample: got %h want %h (tick %0d)", bus.o_sample, tri_exp[i], i); end
    end
  endtask

  task automatic test_saw();
    bit ok;
    logic [SW-1:0] e;
    do_reset();
    wait_cyc(7);
    cfg(0, 24'h100000, 2'd0, 1'b1, 1'b0);
    for (int i = 0; i <= 16; i++) begin
      e = 16'h8000 + 16'(i * 16'h1000);
      exp_q.push_back(e);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      next_valid(ok);
      total++; if (!ok || bus.o_sample !== e) begin bad++; $display("FAIL saw_sample: got %h want %h (valid seen %b)", bus.o_sample, e, ok); end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    do_reset();
    wait_cyc(7);
    cfg(0, 24'h100000, 2'd0, 1'b1, 1'b0);
    next_valid(ok);
    total++; if (bus.o_sample !== 16'h8000) begin bad++; $display("FAIL bp_first: got %h want 8000", bus.o_sample); end
    wait_cyc(30);
    bus.i_ready = 1'b0;
    wait_cyc(38);
    total++; if (bus.o_valid !== 1'b1 || bus.o_sample !== 16'h9000) begin bad++; $display("FAIL bp_held: got valid=%b sample=%h want valid=1 sample=9000", bus.o_valid, bus.o_sample); end
    total++; if (bus.o_overrun !== 1'b0) begin bad++; $display("FAIL bp_no_overrun_yet: got %b want 0", bus.o_overrun); end
    wait_cyc(49);
    total++; if (bus.o_overrun !== 1'b1) begin bad++; $display("FAIL bp_overrun_set: got %b want 1", bus.o_overrun); end
    total++; if (bus.o_valid !== 1'b1 || bus.o_sample !== 16'h9000) begin bad++; $display("FAIL bp_frozen: got valid=%b sample=%h want valid=1 sample=9000", bus.o_valid, bus.o_sample); end
    wait_cyc(80);
    total++; if (bus.o_sample !== 16'h9000) begin bad++; $display("FAIL bp_frozen_late: got %h want 9000", bus.o_sample); end
    bus.i_ready = 1'b1;
    next_valid(ok);
    total++; if (cyc !== 102) begin bad++; $display("FAIL bp_resume_cycle: got cycle %0d want 102", cyc); end
    total++; if (bus.o_sample !== 16'hA000) begin bad++; $display("FAIL bp_resume_sample: got %h want a000", bus.o_sample); end
    total++; if (bus.o_overrun !== 1'b1) begin bad++; $display("FAIL bp_overrun_sticky: got %b want 1", bus.o_overrun); end
  endtask

  task automatic test_scan_write();
    bit ok;
    logic [SW-1:0] sw_exp [5];
    sw_exp = '{16'h8000, 16'h9000, 16'hA000, 16'h8000, 16'h9000};
    do_reset();
    wait_cyc(7);
    cfg(0, 24'h100000, 2'd0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        wait_cyc(49);
        cfg(0, 24'h200000, 2'd0, 1'b1, 1'b1);
        cfg(1, 24'h0, 2'd0, 1'b1, 1'b0);
      end
      next_valid(ok);
      total++; if (!ok || bus.o_sample !== sw_exp[i]) begin bad++; $display("FAIL scan_write_sample: got %h want %h (tick %0d)", bus.o_sample, sw_exp[i], i); end
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    do_reset();
    wait_cyc(7);
    cfg(0, 24'h100000, 2'd0, 1'b1, 1'b0);
    next_valid(ok);
    wait_cyc(30);
    bus.i_ready = 1'b0;
    wait_cyc(50);
    total++; if (bus.o_valid !== 1'b1 || bus.o_overrun !== 1'b1) begin bad++; $display("FAIL arst_pre: got valid=%b overrun=%b want 1 1", bus.o_valid, bus.o_overrun); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (bus.o_valid !== 1'b0) begin bad++; $display("FAIL arst_valid: got %b want 0", bus.o_valid); end
    total++; if (bus.o_sample !== 16'h0000) begin bad++; $display("FAIL arst_sample: got %h want 0000", bus.o_sample); end
    total++; if (bus.o_overrun !== 1'b0) begin bad++; $display("FAIL arst_overrun: got %b want 0", bus.o_overrun); end
    release_reset();
    wait_cyc(7);
    cfg(0, 24'h100000, 2'd0, 1'b1, 1'b0);
    next_valid(ok);
    total++; if (!ok || bus.o_sample !== 16'h8000) begin bad++; $display("FAIL arst_fresh1: got %h want 8000", bus.o_sample); end
    wait_cyc(34);
    total++; if (bus.o_dbg_state !== 2'd1) begin bad++; $display("FAIL arst_in_scan: got state %0d want 1", bus.o_dbg_state); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (bus.o_dbg_state !== 2'd0 || bus.o_valid !== 1'b0) begin bad++; $display("FAIL arst_scan_abort: got state=%0d valid=%b want 0 0", bus.o_dbg_state, bus.o_valid); end
    release_reset();
    wait_cyc(7);
    cfg(0, 24'h100000, 2'd0, 1'b1, 1'b0);
    next_valid(ok);
    total++; if (!ok || bus.o_sample !== 16'h8000) begin bad++; $display("FAIL arst_fresh2: got %h want 8000", bus.o_sample); end
    total++; if (cyc !== 22) begin bad++; $display("FAIL arst_fresh2_latency: got cycle %0d want 22", cyc); end
  endtask

  initial begin
    test_reset();
    test_silent();
    test_square();
    test_triangle();
    test_saw();
    test_backpressure();
    test_scan_write();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
